// File: rtl/async_fifo_pkg.sv
// Shared async FIFO pointer helpers.
// Gray/binary conversion and the full-compare used by both domains.
package async_fifo_pkg;

  localparam int PMAX = 32;

  typedef logic [PMAX-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(
    input ptr_max_t b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(
    input ptr_max_t g
  );
    ptr_max_t b;
    b = '0;
    for (int i = PMAX - 1; i >= 0; i--) begin
      b[i] = g[i] ^ ((i == PMAX - 1) ? 1'b0 : b[i+1]);
    end
    return b;
  endfunction

  // Full when the two top Gray bits are inverted and the rest match.
  function automatic logic full_cmp(
    input ptr_max_t g,
    input ptr_max_t r,
    input int       pw
  );
    ptr_max_t m;
    m = ptr_max_t'(3) << (pw - 2);
    return g == (r ^ m);
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray to binary converter.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_conv #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[W-1:i];
  end

endmodule

// File: rtl/w_ptr_full_ctrl.sv
// Write-side pointer, full, level, almost-full and overflow logic.
// Binary address for RAM, Gray pointer for the synchroniser.
module w_ptr_full_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter bit REG_FULL   = 1'b1
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic                  w_inc,
  input  logic [ADDR_WIDTH:0]   w_q2_r_ptr,
  input  logic [ADDR_WIDTH:0]   w_afull_thresh,
  input  logic                  w_err_clr,
  output logic                  w_full,
  output logic                  w_afull,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH:0]   w_ptr,
  output logic [ADDR_WIDTH:0]   w_level,
  output logic                  w_overflow
);

  localparam int PW = ADDR_WIDTH + 1;

  typedef logic [PW-1:0] ptr_t;

  if (ADDR_WIDTH < 2) begin : g_chk
    $error("w_ptr_full_ctrl: ADDR_WIDTH must be >= 2");
  end

  ptr_t r_bin;
  ptr_t r_ptr;
  ptr_t r_level;
  logic r_afull;
  logic r_ovf;

  ptr_t w_bin_next;
  ptr_t w_gray_next;
  ptr_t w_rbin;
  ptr_t w_level_next;
  logic w_push;
  logic w_full_int;

  assign w_push      = w_inc & ~w_full_int;
  assign w_bin_next  = r_bin + ptr_t'(w_push);
  assign w_gray_next =
    ptr_t'(bin2gray(ptr_max_t'(w_bin_next)));

  gray2bin_conv #(
    .W (PW)
  ) u_g2b (
    .i_gray (w_q2_r_ptr),
    .o_bin  (w_rbin)
  );

  assign w_level_next = w_bin_next - w_rbin;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_bin   <= '0;
      r_ptr   <= '0;
      r_level <= '0;
      r_afull <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_bin   <= w_bin_next;
      r_ptr   <= w_gray_next;
      r_level <= w_level_next;
      r_afull <= (w_level_next >= w_afull_thresh);
      r_ovf   <= (w_inc & w_full_int)
               | (r_ovf & ~w_err_clr);
    end
  end

  if (REG_FULL) begin : g_reg_full
    logic r_full;
    always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
        r_full <= 1'b0;
      end else begin
        r_full <= full_cmp(ptr_max_t'(w_gray_next),
                           ptr_max_t'(w_q2_r_ptr), PW);
      end
    end
    assign w_full_int = r_full;
  end else begin : g_comb_full
    assign w_full_int = full_cmp(ptr_max_t'(r_ptr),
                                 ptr_max_t'(w_q2_r_ptr), PW);
  end

  assign w_full     = w_full_int;
  assign w_afull    = r_afull;
  assign w_addr     = r_bin[ADDR_WIDTH-1:0];
  assign w_ptr      = r_ptr;
  assign w_level    = r_level;
  assign w_overflow = r_ovf;

endmodule

// File: tb/tb_w_ptr_full_ctrl.sv
// Self-checking bench for w_ptr_full_ctrl.
// Registered-full DUT plus a combinational-full twin.
module tb_w_ptr_full_ctrl;

  logic       w_clk = 1'b0;
  logic       w_rst_n;
  logic       w_inc;
  logic [4:0] w_q2_r_ptr;
  logic [4:0] w_afull_thresh;
  logic       w_err_clr;

  logic       full1, afull1, ovf1;
  logic [3:0] addr1;
  logic [4:0] ptr1, lvl1;
  logic       full0, afull0, ovf0;
  logic [3:0] addr0;
  logic [4:0] ptr0, lvl0;

  int n_run  = 0;
  int n_fail = 0;

  always #5 w_clk = ~w_clk;

  w_ptr_full_ctrl #(.ADDR_WIDTH(4), .REG_FULL(1'b1)) dut (
    .w_clk          (w_clk),
    .w_rst_n        (w_rst_n),
    .w_inc          (w_inc),
    .w_q2_r_ptr     (w_q2_r_ptr),
    .w_afull_thresh (w_afull_thresh),
    .w_err_clr      (w_err_clr),
    .w_full         (full1),
    .w_afull        (afull1),
    .w_addr         (addr1),
    .w_ptr          (ptr1),
    .w_level        (lvl1),
    .w_overflow     (ovf1)
  );

  w_ptr_full_ctrl #(.ADDR_WIDTH(4), .REG_FULL(1'b0)) dut0 (
    .w_clk          (w_clk),
    .w_rst_n        (w_rst_n),
    .w_inc          (w_inc),
    .w_q2_r_ptr     (w_q2_r_ptr),
    .w_afull_thresh (w_afull_thresh),
    .w_err_clr      (w_err_clr),
    .w_full         (full0),
    .w_afull        (afull0),
    .w_addr         (addr0),
    .w_ptr          (ptr0),
    .w_level        (lvl0),
    .w_overflow     (ovf0)
  );

  typedef struct {
    logic       inc;
    logic       clr;
    logic [3:0] addr;
    logic [4:0] ptr;
    logic       full;
    logic [4:0] lvl;
    logic       afull;
    logic       ovf;
  } vec_t;

  vec_t tbl[17];

  function automatic logic [4:0] gray(input int k);
    logic [4:0] b;
    b = 5'(k);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  task automatic rst_pulse();
    w_rst_n = 1'b0;
    #2;
    w_rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " dut"},
        {28'(0), full1, afull1, ovf1, 1'b0} |
        {18'(0), addr1, ptr1, lvl1}, 32'd0);
    chk({nm, " dut0"},
        {29'(0), afull0, ovf0, 1'b0} |
        {18'(0), addr0, ptr0, lvl0}, 32'd0);
  endtask

  int wb, rb, lv;

  initial begin
    w_rst_n        = 1'b0;
    w_inc          = 1'b0;
    w_q2_r_ptr     = '0;
    w_afull_thresh = 5'd12;
    w_err_clr      = 1'b0;

    for (int k = 0; k < 16; k++) begin
      tbl[k].inc   = 1'b1;
      tbl[k].clr   = 1'b0;
      tbl[k].addr  = 4'((k + 1) % 16);
      tbl[k].ptr   = gray(k + 1);
      tbl[k].full  = (k == 15);
      tbl[k].lvl   = 5'(k + 1);
      tbl[k].afull = (k + 1 >= 12);
      tbl[k].ovf   = 1'b0;
    end
    tbl[16] = '{inc: 1'b1, clr: 1'b0, addr: 4'd0,
                ptr: 5'b11000, full: 1'b1, lvl: 5'd16,
                afull: 1'b1, ovf: 1'b1};

    #3;
    chk_all_zero("reset");
    chk("reset full0", 32'(full0), 32'd0);
    #9;
    w_rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      w_inc     = tbl[i].inc;
      w_err_clr = tbl[i].clr;
      step();
      chk($sformatf("v%0d addr", i), 32'(addr1), 32'(tbl[i].addr));
      chk($sformatf("v%0d ptr", i), 32'(ptr1), 32'(tbl[i].ptr));
      chk($sformatf("v%0d full", i), 32'(full1), 32'(tbl[i].full));
      chk($sformatf("v%0d lvl", i), 32'(lvl1), 32'(tbl[i].lvl));
      chk($sformatf("v%0d afull", i), 32'(afull1), 32'(tbl[i].afull));
      chk($sformatf("v%0d ovf", i), 32'(ovf1), 32'(tbl[i].ovf));
    end
    chk("comb full at 16", 32'(full0), 32'd1);

    w_inc      = 1'b0;
    w_q2_r_ptr = 5'b00001;
    #1;
    chk("rel comb full", 32'(full0), 32'd0);
    chk("rel reg full pre", 32'(full1), 32'd1);
    step();
    chk("rel reg full", 32'(full1), 32'd0);
    chk("rel lvl", 32'(lvl1), 32'd15);

    rst_pulse();
    w_q2_r_ptr     = '0;
    w_afull_thresh = 5'd17;
    wb = 0;
    rb = 0;
    for (int i = 0; i < 40; i++) begin
      lv = (wb - rb) & 31;
      if (lv >= 2) rb++;
      w_q2_r_ptr = gray(rb);
      w_inc      = 1'b1;
      step();
      wb++;
      chk($sformatf("wr%0d addr", i), 32'(addr1), 32'(wb % 16));
      chk($sformatf("wr%0d ptr", i), 32'(ptr1), 32'(gray(wb)));
      chk($sformatf("wr%0d lvl", i), 32'(lvl1), 32'((wb - rb) & 31));
      chk($sformatf("wr%0d full", i), 32'(full1), 32'd0);
      chk($sformatf("wr%0d afull", i), 32'(afull1), 32'd0);
      if (wb == 31) chk("wrap ptr 31", 32'(ptr1), 32'b10000);
      if (wb == 32) chk("wrap ptr 32", 32'(ptr1), 32'b00000);
    end

    w_inc = 1'b0;
    rst_pulse();
    w_q2_r_ptr     = '0;
    w_afull_thresh = 5'd0;
    chk("th0 pre", 32'(afull1), 32'd0);
    step();
    chk("th0 afull", 32'(afull1), 32'd1);

    rst_pulse();
    w_afull_thresh = 5'd17;
    w_inc          = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("th17 afull %0d", i), 32'(afull1), 32'd0);
    end
    chk("th17 full", 32'(full1), 32'd1);
    chk("th17 lvl", 32'(lvl1), 32'd16);
    step();
    chk("ovf set", 32'(ovf1), 32'd1);
    w_err_clr = 1'b1;
    step();
    chk("ovf set+clr", 32'(ovf1), 32'd1);
    w_inc = 1'b0;
    step();
    chk("ovf clr", 32'(ovf1), 32'd0);
    w_err_clr = 1'b0;

    rst_pulse();
    w_afull_thresh = 5'd12;
    w_inc          = 1'b1;
    for (int i = 0; i < 9; i++) step();
    chk("burst lvl9", 32'(lvl1), 32'd9);
    w_rst_n = 1'b0;
    #1;
    chk_all_zero("mid rst");
    #1;
    w_rst_n = 1'b1;
    chk("post rst addr", 32'(addr1), 32'd0);
    step();
    chk("post rst addr1", 32'(addr1), 32'd1);
    chk("post rst ptr", 32'(ptr1), 32'b00001);
    chk("post rst lvl", 32'(lvl1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/w_ptr_full_ctrl.md
# w_ptr_full_ctrl

Write-domain pointer and flag controller for the async FIFO: the parametrised successor of the basic write-pointer/full block. It keeps the binary write address and Gray write pointer. It adds a selectable registered or combinational full flag, write-side occupancy, a programmable almost-full flag and a sticky overflow flag. It sits between the write client, the dual-port RAM write port and the write→read Gray pointer synchroniser, and consumes the synchronised read pointer.

## Interface
- ADDR_WIDTH, 4, RAM address bits; depth DEPTH = 2^ADDR_WIDTH; must be ≥ 2 (elaboration error otherwise).
- REG_FULL, 1, 1 = w_full registered from next-state compare; 0 = w_full combinational from current state.
- w_clk  in  1  write-domain clock.
- w_rst_n  in  1  reset, asynchronous, active-low.
- w_inc  in  1  write request.
- w_q2_r_ptr  in  ADDR_WIDTH+1  read pointer, Gray, already synchronised into w_clk.
- w_afull_thresh  in  ADDR_WIDTH+1  almost-full level, quasi-static.
- w_err_clr  in  1  clears w_overflow.
- w_full  out  1  FIFO full; writes are blocked.
- w_afull  out  1  occupancy ≥ w_afull_thresh.
- w_addr  out  ADDR_WIDTH  RAM write address (binary).
- w_ptr  out  ADDR_WIDTH+1  write pointer, Gray, registered, to the synchroniser.
- w_level  out  ADDR_WIDTH+1  occupancy seen from the write side, 0..DEPTH.
- w_overflow  out  1  sticky: a write was attempted while full.

## Operation
- w_push = w_inc & ~w_full. Only w_push advances the pointer.
- w_bin_next = w_bin + w_push, modulo 2^(ADDR_WIDTH+1). w_gray_next = w_bin_next ^ (w_bin_next >> 1).
- w_addr = w_bin[ADDR_WIDTH-1:0]. w_ptr is registered w_gray_next.
- Full compare full(g) = (g == {~w_q2_r_ptr[MSB:MSB-1], w_q2_r_ptr[MSB-2:0]}).
  - REG_FULL=1: w_full <= full(w_gray_next).
  - REG_FULL=0: w_full = full(w_ptr).
- r_bin = gray2bin(w_q2_r_ptr). w_level <= (w_bin_next − r_bin) mod 2^(ADDR_WIDTH+1).
- w_afull <= (w_level_next ≥ w_afull_thresh), unsigned compare.
  - Thresh 0 gives a constant 1 after the first edge.
  - Thresh > DEPTH means never asserted.
- w_overflow <= (w_inc & w_full) | (w_overflow & ~w_err_clr). Set wins over a simultaneous clear.
- Wrap-around: w_bin goes 2^(ADDR_WIDTH+1)−1 → 0 with no special handling. The extra MSB distinguishes full from empty.

## Timing
- Reset (asynchronous): w_bin, w_addr, w_ptr, w_level = 0. w_full, w_afull, w_overflow = 0. Reset mid-operation discards all state; the next write goes to address 0.
- w_addr and w_ptr change on the w_clk edge that samples w_push=1. Latency is 1 cycle from request to the new address.
- REG_FULL=1:
  - w_full rises on the same edge as the write that fills the FIFO, so there is no write window past full.
  - w_full falls one edge after w_q2_r_ptr advances. This is conservative and never causes overflow.
- REG_FULL=0: w_full follows w_ptr and w_q2_r_ptr combinationally.
- w_level and w_afull are registered and reflect the current edge's push and the current w_q2_r_ptr.
- Simultaneous push and read-pointer advance: w_level stays the same; w_full is re-evaluated per the rules above.

## Structure
- Package async_fifo_pkg holds:
  - the bin2gray/gray2bin functions;
  - the ptr_t typedef, parameterised width via module-local typedef;
  - the full-compare function, shared with the read-side empty logic.
- One sub-module, gray2bin_conv (parametrised width, combinational XOR prefix). It converts w_q2_r_ptr and is reused on the read side.
- No other hierarchy.

## Test plan
- ADDR_WIDTH=4, REG_FULL=1, w_q2_r_ptr=0, 16 consecutive w_inc.
  - Required: w_addr 0..15; w_ptr 00000, 00001, 00011, 00010, …; w_full=1 and w_level=16 after the 16th edge.
  - A 17th w_inc leaves w_addr=0 and w_ptr=11000, and sets w_overflow=1.
- From full, w_q2_r_ptr → 00001.
  - Required: w_full=0 one edge later (REG_FULL=1) or immediately (REG_FULL=0); w_level=15.
- 40 writes with reads keeping level ≤ 3.
  - Required: w_bin wraps 31→0 and w_ptr goes 10000→00000; w_full never asserts; w_level always equals the model.
- w_afull_thresh sweep.
  - thresh=12: w_afull rises on the edge where w_level becomes 12.
  - thresh=0: w_afull=1 from the first edge after reset.
  - thresh=17: w_afull never asserts.
- Overflow flag clear rules.
  - w_err_clr together with w_inc&w_full: w_overflow stays 1.
  - w_err_clr alone: w_overflow is 0 next edge.
- Assert w_rst_n=0 at level 9 mid-burst.
  - Required: all outputs 0 immediately; after release the first write uses w_addr=0.
